// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised oversampling UART receiver with configurable data
//            width, parity and stop bits. Reports framing, parity and overrun
//            errors and holds each word behind a valid/ready handshake.
// Options  : define UART_RX_MAJORITY_EN to take every bit as the 2-of-3
//            majority of three samples around mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] HALF     = SW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_sync;
  logic [DW-1:0]          div_cnt;
  logic                   tick;
  logic [SW-1:0]          s_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   ferr_acc;
  logic                   perr_acc;
  logic                   w_bit;
  logic                   w_sample;
  logic                   w_last_stop;
  logic                   w_ferr;
  logic                   w_leave_idle;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign w_leave_idle = (state == IDLE) && !rx_sync;
  assign tick         = (div_cnt == DIV_LAST);

  // Free-running oversample tick divider, realigned to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (w_leave_idle || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] HALF_M1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_PT = SW'(OVERSAMPLE / 2 + 1);

  logic s_early;
  logic s_mid;

  // Capture the two samples preceding the decision point for the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (tick) begin
      if (s_cnt == HALF_M1) s_early <= rx_sync;
      if (s_cnt == HALF)    s_mid   <= rx_sync;
    end
  end

  assign w_bit = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);
`else
  localparam logic [SW-1:0] SAMPLE_PT = HALF;

  assign w_bit = rx_sync;
`endif

  assign w_sample    = tick && (s_cnt == SAMPLE_PT);
  assign w_last_stop = (STOP_BITS == 1) || stop_cnt;
  assign w_ferr      = ferr_acc | ~w_bit;
  assign busy        = (state != IDLE);

  // Frame sequencing FSM with the output word register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
      perr_acc   <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      // Sample counter keeps running across states so bit cells stay aligned.
      if (state != IDLE && tick) s_cnt <= s_cnt + SW'(1);

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
          end
        end
        START: begin
          if (w_sample) state <= w_bit ? IDLE : DATA;
        end
        DATA: begin
          if (w_sample) begin
            shreg   <= {w_bit, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: begin
          if (w_sample) begin
            perr_acc <= (w_bit != ((^shreg) ^ (PARITY == 2)));
            state    <= STOP;
          end
        end
        STOP: begin
          if (w_sample) begin
            if (!w_last_stop) begin
              stop_cnt <= 1'b1;
              ferr_acc <= w_ferr;
            end else begin
              // Leave half a bit early so a back-to-back start is not missed.
              state <= w_ferr ? BRK : IDLE;
              if (!m_valid || m_ready) begin
                m_data     <= shreg;
                frame_err  <= w_ferr;
                parity_err <= perr_acc;
                m_valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        BRK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E1
//            instance driven with directed frames at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1;
  logic       m_ready0, m_ready1;
  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic       frame_err0, frame_err1;
  logic       parity_err0, parity_err1;
  logic       overrun0, overrun1;
  logic       busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt0 = 0;
  int ov_base;

  // Expected words: {data[7:0], frame_err, parity_err}
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready0), .frame_err(frame_err0), .parity_err(parity_err0),
    .overrun(overrun0), .busy(busy0));

  uart_rx_cfg #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .frame_err(frame_err1), .parity_err(parity_err1),
    .overrun(overrun1), .busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx0 = v;
    else        rx1 = v;
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, stop level held
  // for stop_clks. spike_bit >= 0 inverts one clock at mid-cell of that bit.
  task automatic send(input int d, input logic [7:0] data, input bit use_par,
                      input bit par_bit, input bit stop_val, input int stop_clks,
                      input int spike_bit);
    set_rx(d, 1'b0);
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(d, data[i]);
      if (i == spike_bit) begin
        wait_clks(9);
        set_rx(d, ~data[i]);
        wait_clks(1);
        set_rx(d, data[i]);
        wait_clks(6);
      end else begin
        wait_clks(16);
      end
    end
    if (use_par) begin
      set_rx(d, par_bit);
      wait_clks(16);
    end
    set_rx(d, stop_val);
    wait_clks(stop_clks);
  endtask

  // Scoreboard monitors: compare each word as it is handed over.
  always @(negedge clk) begin
    if (m_valid0 && m_ready0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected word", {24'h0, m_data0}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = q0.pop_front();
        chk("dut0 data", {24'h0, m_data0}, {24'h0, e[9:2]});
        chk("dut0 frame_err", {31'h0, frame_err0}, {31'h0, e[1]});
        chk("dut0 parity_err", {31'h0, parity_err0}, {31'h0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid1 && m_ready1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected word", {24'h0, m_data1}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = q1.pop_front();
        chk("dut1 data", {24'h0, m_data1}, {24'h0, e[9:2]});
        chk("dut1 frame_err", {31'h0, frame_err1}, {31'h0, e[1]});
        chk("dut1 parity_err", {31'h0, parity_err1}, {31'h0, e[0]});
      end
    end
  end

  always @(negedge clk) if (overrun0) ov_cnt0++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; m_ready0 = 1'b0; m_ready1 = 1'b1;
    wait_clks(3);
    chk("reset m_valid", {31'h0, m_valid0}, 32'h0);
    chk("reset m_data", {24'h0, m_data0}, 32'h0);
    chk("reset frame_err", {31'h0, frame_err0}, 32'h0);
    chk("reset parity_err", {31'h0, parity_err0}, 32'h0);
    chk("reset overrun", {31'h0, overrun0}, 32'h0);
    chk("reset busy", {31'h0, busy0}, 32'h0);
    rst_n = 1'b1;
    wait_clks(5);

    // 8N1 0xA5 held until m_ready, then valid clears the next cycle
    q0.push_back({8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 0, 0, 1, 16, -1);
    chk("A5 valid held", {31'h0, m_valid0}, 32'h1);
    chk("A5 busy idle", {31'h0, busy0}, 32'h0);
    m_ready0 = 1'b1;
    wait_clks(1);
    chk("A5 valid cleared", {31'h0, m_valid0}, 32'h0);
    wait_clks(10);

    // Even parity: 0x03 has even ones, so parity bit 1 is wrong, 0 is right
    q1.push_back({8'h03, 1'b0, 1'b1});
    send(1, 8'h03, 1, 1, 1, 16, -1);
    q1.push_back({8'h03, 1'b0, 1'b0});
    send(1, 8'h03, 1, 0, 1, 16, -1);
    wait_clks(10);

    // Framing error with a long break, then a clean word
    q0.push_back({8'h7E, 1'b1, 1'b0});
    send(0, 8'h7E, 0, 0, 0, 40, -1);
    chk("break busy", {31'h0, busy0}, 32'h1);
    rx0 = 1'b1;
    wait_clks(6);
    chk("break released busy", {31'h0, busy0}, 32'h0);
    q0.push_back({8'h42, 1'b0, 1'b0});
    send(0, 8'h42, 0, 0, 1, 16, -1);
    wait_clks(10);

    // Overrun: second back-to-back word is dropped, first stays held
    m_ready0 = 1'b0;
    ov_base = ov_cnt0;
    q0.push_back({8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 0, 0, 1, 16, -1);
    send(0, 8'h22, 0, 0, 1, 16, -1);
    wait_clks(4);
    chk("overrun pulses", ov_cnt0 - ov_base, 32'd1);
    chk("overrun held data", {24'h0, m_data0}, 32'h11);
    chk("overrun valid held", {31'h0, m_valid0}, 32'h1);
    m_ready0 = 1'b1;
    wait_clks(1);
    chk("overrun valid cleared", {31'h0, m_valid0}, 32'h0);
    wait_clks(10);

    // Short glitch on the line is not a start bit
    rx0 = 1'b0;
    wait_clks(4);
    rx0 = 1'b1;
    wait_clks(30);
    chk("glitch busy", {31'h0, busy0}, 32'h0);
    chk("glitch no valid", {31'h0, m_valid0}, 32'h0);

`ifdef UART_RX_MAJORITY_EN
    // Single-clock spike at mid-cell of data bit 3 is voted out
    q0.push_back({8'h00, 1'b0, 1'b0});
    send(0, 8'h00, 0, 0, 1, 16, 3);
    wait_clks(10);
`endif

    // Reset mid-frame while a word is held: everything clears at once
    m_ready0 = 1'b0;
    send(0, 8'h33, 0, 0, 1, 16, -1);
    rx0 = 1'b0;
    wait_clks(16);
    rx0 = 1'b0;
    wait_clks(20);
    rst_n = 1'b0;
    #1;
    chk("mid reset m_valid", {31'h0, m_valid0}, 32'h0);
    chk("mid reset m_data", {24'h0, m_data0}, 32'h0);
    chk("mid reset busy", {31'h0, busy0}, 32'h0);
    rx0 = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    m_ready0 = 1'b1;
    wait_clks(5);
    ov_base = ov_cnt0;
    q0.push_back({8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 0, 0, 1, 16, -1);
    wait_clks(10);
    chk("post reset no overrun", ov_cnt0 - ov_base, 32'd0);

    wait_clks(20);
    chk("dut0 words delivered", q0.size(), 32'd0);
    chk("dut1 words delivered", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
